pc_gen: RTL
===========

// Module: pc_gen
// PURPOSE
//  Parametrised fetch-PC generator for the 5-stage core; successor to the single-redirect PC register.
//  Selects next PC by fixed priority: trap > mret > branch/jump redirect > BTB prediction > sequential.
//  Adds an IF-stage valid/ready fetch handshake and a registered misaligned-target exception.
//  Has an optional direct-mapped BTB with 2-bit counters. Sits in IF; drives the imem address and the IF/ID pc.
// PARAMETERS
//  XLEN          32     datapath/PC width
//  RESET_VECTOR  'h0    PC value loaded on reset
//  BTB_ENTRIES   16     BTB depth, power of 2 >= 2 (used only with PC_BTB_EN)
// PORTS
//  clk          in   1     clock
//  rst_n        in   1     asynchronous active-low reset
//  stall        in   1     hazard-unit hold of sequential/predicted advance
//  fetch_ready  in   1     imem accepts the request at pc this cycle
//  fetch_valid  out  1     pc is a valid, aligned fetch request
//  trap_valid   in   1     exception/interrupt redirect (from CSR unit)
//  trap_target  in   XLEN  trap vector (mtvec)
//  mret_valid   in   1     mret redirect
//  mret_target  in   XLEN  mepc
//  br_valid     in   1     EX redirect (mispredict, taken branch or jump)
//  br_target    in   XLEN  EX-computed target
//  upd_valid    in   1     BTB training event from EX (resolved branch/jump)
//  upd_pc       in   XLEN  pc of the resolved instruction
//  upd_target   in   XLEN  resolved target
//  upd_taken    in   1     resolved direction
//  pc           out  XLEN  current fetch PC (registered)
//  pc_next      out  XLEN  combinational next PC (debug)
//  next_src     out  3     pc_pkg::pc_src_e selected this cycle (debug)
//  pred_taken   out  1     BTB predicts taken for pc (travels down the pipe with the instruction)
//  misalign_exc out  1     one-cycle pulse: pc was loaded with target[1:0] != 0
//  misalign_pc  out  XLEN  offending target; held until the next misalign_exc
// BEHAVIOUR
//  Reset values: pc=RESET_VECTOR, fetch_valid=0, misalign_exc=0, misalign_pc=0, pred_taken=0, BTB valid bits=0.
//  fetch_valid rises on the first clk edge after rst_n deasserts.
//  fetch_valid = started && (pc[1:0]==0).
//  advance = fetch_valid && fetch_ready && !stall.
//  pc update on each edge:
//   - any of trap/mret/br valid: load the highest-priority target; stall and fetch_ready are ignored.
//   - else if advance: load BTB target if pred_taken, otherwise pc+XLEN'(4).
//   - else: hold pc.
//  Arithmetic: pc+4 wraps modulo 2^XLEN, so 'hFFFF_FFFC -> 'h0.
//  Simultaneous redirects: the lower-priority ones are dropped for that cycle, not queued.
//  Misalign: a redirect target with [1:0]!=0 is still loaded into pc.
//   - Next cycle: misalign_exc=1 and misalign_pc=target; fetch_valid=0 until a later aligned redirect (normally the trap).
//   - If the next cycle's redirect is also misaligned, misalign_exc pulses again.
//  Reset mid-operation: state is cleared immediately (asynchronous); the next fetch is at RESET_VECTOR.
//  pc_next / next_src reflect the same priority mux, including the hold case (next_src=SRC_HOLD).
// CONFIGURATION
//  PC_BTB_EN defined: direct-mapped BTB.
//   - Addressing: index = pc[IDX+1:2] with IDX = $clog2(BTB_ENTRIES); tag = pc[XLEN-1:IDX+2].
//   - Entry: {valid, tag, target, ctr[1:0]}.
//   - Prediction: pred_taken = hit && ctr[1]; combinational lookup on pc.
//   - Update on upd_valid, hit: ctr saturates up on taken, down on not-taken; target rewritten when taken.
//   - Update on upd_valid, miss && taken: allocate with ctr=2'b10 and the new target.
//   - Update on upd_valid, miss && !taken: no change.
//   - Update and lookup of the same entry in one cycle: the lookup sees the pre-update contents.
//  PC_BTB_EN undefined: no BTB storage; pred_taken tied 0; SRC_BTB never selected; upd_* ignored.
// STRUCTURE
//  pc_pkg:
//   - typedef enum logic [2:0] pc_src_e {SRC_HOLD, SRC_SEQ, SRC_BTB, SRC_BR, SRC_MRET, SRC_TRAP}.
//   - typedef struct btb_entry_t, parameterised through XLEN/IDX localparams.
//   - localparam PC_INC = 4.
//  Sub-module pc_btb (storage, lookup, training), instantiated only under PC_BTB_EN.
//  pc_gen holds the PC register, priority mux, handshake and misalign logic.
// TESTING
//  - Reset release, RESET_VECTOR='h100, fetch_ready=1 -> fetch_valid rises on the next edge; pc = 'h100, 'h104, 'h108.
//  - stall=1 for 3 cycles at pc='h10 -> pc holds 'h10; br_valid with target 'h40 during the stall -> pc='h40 next edge.
//  - trap_valid(mtvec 'h200), mret_valid('h80) and br_valid('h40) in the same cycle -> pc='h200, next_src=SRC_TRAP.
//  - br_target='h42 -> pc='h42, then misalign_exc=1 for one cycle with misalign_pc='h42 and fetch_valid=0; trap to 'h200 restores fetch_valid.
//  - pc='hFFFF_FFFC advancing -> pc='h0000_0000.
//  - PC_BTB_EN: upd taken for pc 'h20 -> 'h80, then fetch 'h20 -> pred_taken=1, next pc='h80.
//    Two not-taken updates -> pred_taken=0, next pc='h24.

Source files
------------

// File: rtl/pc_pkg.sv
// -----------------------------------------------------------------------------
// pc_pkg: shared types and constants for the fetch-PC generator.
//   pc_src_e    : which source fed the PC this cycle (debug / next_src port)
//   btb_entry_t : one BTB entry at the default width (XLEN_DEF / BTB_IDX_DEF)
//   PC_INC      : sequential fetch increment in bytes
//   ctr_update  : 2-bit saturating counter step
// -----------------------------------------------------------------------------
package pc_pkg;

  typedef enum logic [2:0] {
    SRC_HOLD = 3'd0,
    SRC_SEQ  = 3'd1,
    SRC_BTB  = 3'd2,
    SRC_BR   = 3'd3,
    SRC_MRET = 3'd4,
    SRC_TRAP = 3'd5
  } pc_src_e;

  localparam int PC_INC      = 4;
  localparam int XLEN_DEF    = 32;
  localparam int BTB_IDX_DEF = 4;
  localparam int BTB_TAG_DEF = XLEN_DEF - BTB_IDX_DEF - 2;

  typedef struct packed {
    logic                   valid;
    logic [BTB_TAG_DEF-1:0] tag;
    logic [XLEN_DEF-1:0]    target;
    logic [1:0]             ctr;
  } btb_entry_t;

  // Saturating 2-bit counter: up on taken, down on not-taken.
  function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic taken);
    logic [1:0] r;
    r = ctr;
    if (taken && ctr != 2'b11) r = ctr + 2'b01;
    else if (!taken && ctr != 2'b00) r = ctr - 2'b01;
    return r;
  endfunction

endpackage

// File: rtl/pc_btb.sv
// -----------------------------------------------------------------------------
// pc_btb: direct-mapped branch target buffer with 2-bit direction counters.
//   clk, rst_n       : clock, asynchronous active-low reset (clears all entries)
//   lookup_pc        : fetch PC to predict for (combinational lookup)
//   pred_taken       : entry hits and its counter MSB is set
//   pred_target      : stored target of the looked-up entry
//   upd_valid/pc/target/taken : training event from a resolved branch/jump
// Lookup reads the array before this cycle's update is written, so a same-entry
// update and lookup in one cycle sees the old contents.
// -----------------------------------------------------------------------------
module pc_btb
  import pc_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BTB_ENTRIES = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_taken
);

  localparam int IDX = $clog2(BTB_ENTRIES);
  localparam int TAG = XLEN - IDX - 2;

  typedef struct packed {
    logic            valid;
    logic [TAG-1:0]  tag;
    logic [XLEN-1:0] target;
    logic [1:0]      ctr;
  } entry_t;

  entry_t mem [BTB_ENTRIES];

  logic [IDX-1:0] lk_idx;
  logic [TAG-1:0] lk_tag;
  entry_t         lk_e;
  logic [IDX-1:0] up_idx;
  logic [TAG-1:0] up_tag;
  entry_t         up_e;
  logic           up_hit;
  logic           unused_lsb;

  // Instruction addresses are word aligned; the low two bits never index.
  assign unused_lsb = ^{lookup_pc[1:0], upd_pc[1:0]};

  assign lk_idx      = lookup_pc[IDX+1:2];
  assign lk_tag      = lookup_pc[XLEN-1:IDX+2];
  assign lk_e        = mem[lk_idx];
  assign pred_taken  = lk_e.valid && (lk_e.tag == lk_tag) && lk_e.ctr[1];
  assign pred_target = lk_e.target;

  assign up_idx = upd_pc[IDX+1:2];
  assign up_tag = upd_pc[XLEN-1:IDX+2];
  assign up_e   = mem[up_idx];
  assign up_hit = up_e.valid && (up_e.tag == up_tag);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BTB_ENTRIES; i++) mem[i] <= '0;
    end else if (upd_valid) begin
      if (up_hit) begin
        mem[up_idx].ctr <= ctr_update(up_e.ctr, upd_taken);
        if (upd_taken) mem[up_idx].target <= upd_target;
      end else if (upd_taken) begin
        // Fresh entries start weakly taken.
        mem[up_idx] <= '{valid: 1'b1, tag: up_tag, target: upd_target, ctr: 2'b10};
      end
    end
  end

endmodule

// File: rtl/pc_gen.sv
// -----------------------------------------------------------------------------
// pc_gen: fetch-PC generator for the IF stage.
// Next PC priority: trap > mret > branch/jump redirect > BTB prediction > pc+4.
// Optional BTB enabled by defining PC_BTB_EN (default build has no BTB).
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   stall             : holds sequential/predicted advance (redirects ignore it)
//   fetch_ready       : imem accepts the request at pc
//   fetch_valid       : pc is a valid, aligned fetch request
//   trap_*/mret_*/br_*: redirect requests with targets
//   upd_*             : BTB training from EX (ignored without PC_BTB_EN)
//   pc                : registered fetch PC
//   pc_next, next_src : combinational next PC and its source (debug)
//   pred_taken        : BTB predicts taken for pc
//   misalign_exc      : one-cycle pulse after a misaligned redirect was loaded
//   misalign_pc       : last misaligned target, held until the next pulse
// Handshake: a fetch request is transferred on a clock edge where
// fetch_valid && fetch_ready are both high and stall is low; only then does
// pc move on without a redirect. fetch_valid does not depend on fetch_ready.
// -----------------------------------------------------------------------------
module pc_gen
  import pc_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              BTB_ENTRIES  = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            fetch_ready,
  output logic            fetch_valid,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_target,
  input  logic            mret_valid,
  input  logic [XLEN-1:0] mret_target,
  input  logic            br_valid,
  input  logic [XLEN-1:0] br_target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_taken,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_next,
  output logic [2:0]      next_src,
  output logic            pred_taken,
  output logic            misalign_exc,
  output logic [XLEN-1:0] misalign_pc
);

  logic            started;
  logic            advance;
  logic            redirect;
  logic            target_misaligned;
  logic [XLEN-1:0] btb_target;
  pc_src_e         src;

`ifdef PC_BTB_EN
  pc_btb #(
    .XLEN        (XLEN),
    .BTB_ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk         (clk),
    .rst_n       (rst_n),
    .lookup_pc   (pc),
    .pred_taken  (pred_taken),
    .pred_target (btb_target),
    .upd_valid   (upd_valid),
    .upd_pc      (upd_pc),
    .upd_target  (upd_target),
    .upd_taken   (upd_taken)
  );
`else
  localparam int unused_btb_entries = BTB_ENTRIES;
  logic unused_upd;
  assign unused_upd = ^{upd_valid, upd_pc, upd_target, upd_taken};
  assign pred_taken = 1'b0;
  assign btb_target = '0;
`endif

  // A misaligned pc stays put (no fetch) until a redirect replaces it.
  assign fetch_valid = started && (pc[1:0] == 2'b00);
  assign advance     = fetch_valid && fetch_ready && !stall;
  assign redirect    = trap_valid || mret_valid || br_valid;

  always_comb begin
    pc_next = pc;
    src     = SRC_HOLD;
    if (trap_valid) begin
      pc_next = trap_target;
      src     = SRC_TRAP;
    end else if (mret_valid) begin
      pc_next = mret_target;
      src     = SRC_MRET;
    end else if (br_valid) begin
      pc_next = br_target;
      src     = SRC_BR;
    end else if (advance) begin
      if (pred_taken) begin
        pc_next = btb_target;
        src     = SRC_BTB;
      end else begin
        pc_next = pc + XLEN'(PC_INC);
        src     = SRC_SEQ;
      end
    end
  end

  assign next_src          = src;
  assign target_misaligned = redirect && (pc_next[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc           <= RESET_VECTOR;
      started      <= 1'b0;
      misalign_exc <= 1'b0;
      misalign_pc  <= '0;
    end else begin
      pc           <= pc_next;
      started      <= 1'b1;
      misalign_exc <= target_misaligned;
      if (target_misaligned) misalign_pc <= pc_next;
    end
  end

endmodule
